// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states, opcodes,
// function codes, ALU operations and datapath select values.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR
    } state_t;

    // Which kind of ALU work the current state performs
    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ADD,
        CLS_SUB,
        CLS_R,
        CLS_I
    } alu_cls_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_SLTI = 6'd10;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [5:0] FN_JR  = 6'd8;
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    function automatic logic is_legal_func(input logic [5:0] func);
        return func inside {FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU operation decode from the state's ALU class plus the
// instruction's OpCode/Func; also flags whether Func is a supported R-type.
module alu_op_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_cls_t    cls,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    output logic [2:0]  alu_op,
    output logic        func_legal
);

    always_comb begin
        alu_op = ALU_AND;
        case (cls)
            CLS_ADD: alu_op = ALU_ADD;
            CLS_SUB: alu_op = ALU_SUB;
            CLS_I:   alu_op = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            CLS_R: begin
                case (func)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_AND;
                endcase
            end
            default: alu_op = ALU_AND;
        endcase
    end

    assign func_legal = is_legal_func(func);

endmodule

// File: rtl/multi_cycle_controller.sv
// FSM controller for the multi-cycle MIPS-subset datapath, one state per clock,
// stalling on MemReady. Define MC_CTRL_BNE_EN to decode bne (opcode 5).
module multi_cycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Func,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCEn,
    output logic [1:0]  PCSrc,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  RegDst,
    output logic        RegWSrc,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOperation,
    output logic        IllegalOp
);

    state_t   state, next_state;
    alu_cls_t cls;
    logic [2:0] alu_op;
    logic       func_legal;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= S_FETCH;
        else      state <= next_state;
    end

    always_comb begin
        cls = CLS_NONE;
        case (state)
            S_FETCH, S_DECODE, S_MEM_ADDR: cls = CLS_ADD;
            S_R_EXEC:                      cls = CLS_R;
            S_I_EXEC:                      cls = CLS_I;
            S_BRANCH:                      cls = CLS_SUB;
            default:                       cls = CLS_NONE;
        endcase
    end

    alu_op_decoder u_alu_dec (
        .cls        (cls),
        .opcode     (OpCode),
        .func       (Func),
        .alu_op     (alu_op),
        .func_legal (func_legal)
    );

    always_comb begin
        next_state   = state;
        PCEn         = 1'b0;
        PCSrc        = PCSRC_ALU;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = REGDST_RT;
        RegWSrc      = 1'b0;
        MemToReg     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_RT;
        ALUOperation = alu_op;
        IllegalOp    = 1'b0;

        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                PCEn    = MemReady;
                IRWrite = MemReady;
                if (MemReady) next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                case (OpCode)
                    OP_R: begin
                        if (!func_legal) begin
                            IllegalOp  = 1'b1;
                            next_state = S_FETCH;
                        end else if (Func == FN_JR) begin
                            next_state = S_JR;
                        end else begin
                            next_state = S_R_EXEC;
                        end
                    end
                    OP_LW, OP_SW:     next_state = S_MEM_ADDR;
                    OP_ADDI, OP_SLTI: next_state = S_I_EXEC;
                    OP_BEQ:           next_state = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:           next_state = S_BRANCH;
`endif
                    OP_J:             next_state = S_JUMP;
                    OP_JAL:           next_state = S_JAL;
                    default: begin
                        IllegalOp  = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_R_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_RT;
                next_state = S_R_WB;
            end
            S_R_WB: begin
                RegDst     = REGDST_RD;
                RegWSrc    = 1'b1;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_I_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                next_state = S_I_WB;
            end
            S_I_WB: begin
                RegDst     = REGDST_RT;
                RegWSrc    = 1'b1;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                next_state = (OpCode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegDst     = REGDST_RT;
                MemToReg   = 1'b1;
                RegWSrc    = 1'b1;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_RT;
                PCSrc   = PCSRC_ALUOUT;
`ifdef MC_CTRL_BNE_EN
                PCEn    = (OpCode == OP_BNE) ? !Zero : Zero;
`else
                PCEn    = Zero;
`endif
                next_state = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = PCSRC_JUMP;
                PCEn       = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                PCSrc      = PCSRC_JUMP;
                PCEn       = 1'b1;
                RegDst     = REGDST_RA;
                RegWSrc    = 1'b0;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_JR: begin
                PCSrc      = PCSRC_RS;
                PCEn       = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase

        // Reset drops every request and select immediately, not at the next edge
        if (!Rst) begin
            PCEn         = 1'b0;
            PCSrc        = 2'b00;
            IorD         = 1'b0;
            MemRead      = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            RegDst       = 2'b00;
            RegWSrc      = 1'b0;
            MemToReg     = 1'b0;
            RegWrite     = 1'b0;
            ALUSrcA      = 1'b0;
            ALUSrcB      = 2'b00;
            ALUOperation = 3'b000;
            IllegalOp    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed-vector bench for multi_cycle_controller: whole control word checked
// per cycle against hand-built expected words.
module tb_multi_cycle_controller;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [5:0]  OpCode;
    logic [5:0]  Func;
    logic        Zero;
    logic        MemReady;
    logic        PCEn, IorD, MemRead, MemWrite, IRWrite, RegWSrc, MemToReg, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0]  PCSrc, RegDst, ALUSrcB;
    logic [2:0]  ALUOperation;
    logic [18:0] obs;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 Clk = ~Clk;

    multi_cycle_controller dut (
        .Clk(Clk), .Rst(Rst), .OpCode(OpCode), .Func(Func), .Zero(Zero), .MemReady(MemReady),
        .PCEn(PCEn), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .RegWSrc(RegWSrc), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOperation(ALUOperation), .IllegalOp(IllegalOp)
    );

    assign obs = {PCEn, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegDst, RegWSrc,
                  MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, IllegalOp};

    function automatic logic [18:0] cw(input logic pcen, input logic [1:0] pcsrc,
        input logic iord, input logic mr, input logic mw, input logic irw,
        input logic [1:0] rdst, input logic rws, input logic m2r, input logic rw,
        input logic srca, input logic [1:0] srcb, input logic [2:0] aop, input logic ill);
        return {pcen, pcsrc, iord, mr, mw, irw, rdst, rws, m2r, rw, srca, srcb, aop, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check the word mid-cycle, then step to just after the next rising edge
    task automatic cyc(input string tag, input logic [18:0] exp);
        @(negedge Clk);
        chk(tag, {13'd0, obs}, {13'd0, exp});
        @(posedge Clk);
        #1;
    endtask

    logic [18:0] w_f1, w_f0, w_d, w_dill, w_rwb, w_iwb, w_ma, w_mr, w_mwb, w_mw;
    logic [18:0] w_j, w_jal, w_jr;
    logic [5:0]  fn_tab [4];
    logic [2:0]  aop_tab[4];

    initial begin
        w_f1   = cw(1, 2'd0, 0, 1, 0, 1, 2'd0, 0, 0, 0, 0, 2'd1, 3'd2, 0);
        w_f0   = cw(0, 2'd0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd1, 3'd2, 0);
        w_d    = cw(0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd3, 3'd2, 0);
        w_dill = cw(0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd3, 3'd2, 1);
        w_rwb  = cw(0, 2'd0, 0, 0, 0, 0, 2'd1, 1, 0, 1, 0, 2'd0, 3'd0, 0);
        w_iwb  = cw(0, 2'd0, 0, 0, 0, 0, 2'd0, 1, 0, 1, 0, 2'd0, 3'd0, 0);
        w_ma   = cw(0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd2, 3'd2, 0);
        w_mr   = cw(0, 2'd0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 0);
        w_mwb  = cw(0, 2'd0, 0, 0, 0, 0, 2'd0, 1, 1, 1, 0, 2'd0, 3'd0, 0);
        w_mw   = cw(0, 2'd0, 1, 0, 1, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 0);
        w_j    = cw(1, 2'd2, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 0);
        w_jal  = cw(1, 2'd2, 0, 0, 0, 0, 2'd2, 0, 0, 1, 0, 2'd0, 3'd0, 0);
        w_jr   = cw(1, 2'd3, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 3'd0, 0);
        fn_tab  = '{6'd34, 6'd36, 6'd37, 6'd42};
        aop_tab = '{3'b110, 3'b000, 3'b001, 3'b111};

        Rst = 1'b0; OpCode = 6'd0; Func = 6'd32; Zero = 1'b0; MemReady = 1'b1;
        cyc("rst0", 19'd0);
        cyc("rst1", 19'd0);
        Rst = 1'b1;

        // add $3,$1,$2
        cyc("add_f", w_f1);
        cyc("add_d", w_d);
        cyc("add_ex", cw(0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 3'd2, 0));
        cyc("add_wb", w_rwb);

        // remaining R-type ALU functions
        for (int i = 0; i < 4; i++) begin
            Func = fn_tab[i];
            cyc("r_f", w_f1);
            cyc("r_d", w_d);
            cyc("r_ex", cw(0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd0, aop_tab[i], 0));
            cyc("r_wb", w_rwb);
        end

        // lw with 2 wait cycles in FETCH and 3 in MEM_READ: 10 cycles
        OpCode = 6'd35; MemReady = 1'b0;
        cyc("lw_fw0", w_f0);
        cyc("lw_fw1", w_f0);
        MemReady = 1'b1;
        cyc("lw_f", w_f1);
        cyc("lw_d", w_d);
        cyc("lw_ma", w_ma);
        MemReady = 1'b0;
        cyc("lw_mr0", w_mr);
        cyc("lw_mr1", w_mr);
        cyc("lw_mr2", w_mr);
        MemReady = 1'b1;
        cyc("lw_mr3", w_mr);
        cyc("lw_wb", w_mwb);

        // sw, addi, slti
        OpCode = 6'd43;
        cyc("sw_f", w_f1);
        cyc("sw_d", w_d);
        cyc("sw_ma", w_ma);
        cyc("sw_mw", w_mw);
        OpCode = 6'd8;
        cyc("addi_f", w_f1);
        cyc("addi_d", w_d);
        cyc("addi_ex", cw(0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd2, 3'd2, 0));
        cyc("addi_wb", w_iwb);
        OpCode = 6'd10;
        cyc("slti_f", w_f1);
        cyc("slti_d", w_d);
        cyc("slti_ex", cw(0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd2, 3'd7, 0));
        cyc("slti_wb", w_iwb);

        // beq taken / not taken
        OpCode = 6'd4; Zero = 1'b1;
        cyc("beqT_f", w_f1);
        cyc("beqT_d", w_d);
        cyc("beqT_br", cw(1, 2'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 3'd6, 0));
        Zero = 1'b0;
        cyc("beqN_f", w_f1);
        cyc("beqN_d", w_d);
        cyc("beqN_br", cw(0, 2'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 3'd6, 0));

        // jumps
        OpCode = 6'd3;
        cyc("jal_f", w_f1);
        cyc("jal_d", w_d);
        cyc("jal_x", w_jal);
        OpCode = 6'd0; Func = 6'd8;
        cyc("jr_f", w_f1);
        cyc("jr_d", w_d);
        cyc("jr_x", w_jr);
        OpCode = 6'd2;
        cyc("j_f", w_f1);
        cyc("j_d", w_d);
        cyc("j_x", w_j);

        // illegal opcode, illegal func
        OpCode = 6'd63;
        cyc("ill_f", w_f1);
        cyc("ill_d", w_dill);
        OpCode = 6'd0; Func = 6'd0;
        cyc("illfn_f", w_f1);
        cyc("illfn_d", w_dill);

        // opcode 5
        OpCode = 6'd5; Zero = 1'b0;
        cyc("bne_f", w_f1);
`ifdef MC_CTRL_BNE_EN
        cyc("bne_d", w_d);
        cyc("bneT_br", cw(1, 2'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 3'd6, 0));
        Zero = 1'b1;
        cyc("bneN_f", w_f1);
        cyc("bneN_d", w_d);
        cyc("bneN_br", cw(0, 2'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 3'd6, 0));
`else
        cyc("bne_d", w_dill);
`endif
        cyc("post5_f", w_f1);
        cyc("post5_d", w_dill);

        // async reset in MEM_WRITE while memory is stalled
        OpCode = 6'd43;
        cyc("rsw_f", w_f1);
        cyc("rsw_d", w_d);
        cyc("rsw_ma", w_ma);
        MemReady = 1'b0;
        @(negedge Clk);
        chk("rsw_mw", {13'd0, obs}, {13'd0, w_mw});
        #2 Rst = 1'b0;
        #1 chk("rst_async", {13'd0, obs}, 32'd0);
        @(posedge Clk);
        #1 chk("rst_hold", {13'd0, obs}, 32'd0);
        Rst = 1'b1;
        cyc("rel_fw", w_f0);
        MemReady = 1'b1; OpCode = 6'd2;
        cyc("rel_f", w_f1);
        cyc("rel_d", w_d);
        cyc("rel_j", w_j);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
